// File: rtl/kmer_reduce_pipe.sv
// kmer_reduce_pipe: pipelined FANIN-ary bit-reduction tree for the seed-match path.
// Each beat reduces a WIDTH-bit match vector to one bit with its own mode
// (AND/OR/XOR/NAND). The valid and mode bits travel alongside the data.
// Optional saturating hit counter, compiled in with `define KMER_REDUCE_HIT_CNT_EN.
module kmer_reduce_pipe #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned FANIN = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_bits,
  input  logic [1:0]       in_mode,
  input  logic             cnt_clear,
  output logic             out_valid,
  output logic             out_bit,
  output logic [CNT_W-1:0] hit_count
);

  typedef enum logic [1:0] {
    MODE_AND  = 2'b00,
    MODE_OR   = 2'b01,
    MODE_XOR  = 2'b10,
    MODE_NAND = 2'b11
  } mode_e;

  // Node count after 'stage' levels of grouping. Nested ceilings equal ceil(WIDTH/FANIN^stage).
  function automatic int unsigned f_nodes(input int unsigned stage);
    int unsigned n;
    n = WIDTH;
    for (int unsigned i = 0; i < stage; i++) begin
      n = (n + FANIN - 1) / FANIN;
    end
    return n;
  endfunction

  // Smallest L >= 1 that collapses WIDTH down to a single node.
  function automatic int unsigned f_levels();
    int unsigned n;
    int unsigned l;
    n = (WIDTH + FANIN - 1) / FANIN;
    l = 1;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      l++;
    end
    return l;
  endfunction

  localparam int unsigned LEVELS = f_levels();

  for (genvar k = 0; k < LEVELS; k++) begin : g_stage
    localparam int unsigned IN_N  = f_nodes(k);
    localparam int unsigned OUT_N = f_nodes(k + 1);

    logic [IN_N-1:0]        w_in;
    logic                   w_in_vld;
    mode_e                  w_in_mode;
    logic                   w_pad;
    logic [OUT_N*FANIN-1:0] w_padded;
    logic [OUT_N-1:0]       w_red;

    logic [OUT_N-1:0]       r_node;
    logic                   r_vld;
    mode_e                  r_mode;

    if (k == 0) begin : g_src_in
      assign w_in      = in_bits;
      assign w_in_vld  = in_valid;
      assign w_in_mode = mode_e'(in_mode);
    end else begin : g_src_prev
      assign w_in      = g_stage[k-1].r_node;
      assign w_in_vld  = g_stage[k-1].r_vld;
      assign w_in_mode = g_stage[k-1].r_mode;
    end

    // Identity of the carried mode: 1 for AND/NAND, 0 for OR/XOR.
    assign w_pad = (w_in_mode == MODE_AND) || (w_in_mode == MODE_NAND);

    // Pad the short last group with the identity, then reduce each group LSB-first.
    // NAND nodes reduce as AND; the inversion is applied once at the output.
    always_comb begin
      w_padded             = {(OUT_N*FANIN){w_pad}};
      w_padded[IN_N-1:0]   = w_in;
      w_red                = '0;
      for (int unsigned j = 0; j < OUT_N; j++) begin
        case (w_in_mode)
          MODE_OR:  w_red[j] = |w_padded[j*FANIN +: FANIN];
          MODE_XOR: w_red[j] = ^w_padded[j*FANIN +: FANIN];
          default:  w_red[j] = &w_padded[j*FANIN +: FANIN];
        endcase
      end
    end

    // Stage register: data loads every cycle, valid and mode follow their data.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_node <= '0;
        r_vld  <= 1'b0;
        r_mode <= MODE_AND;
      end else begin
        r_node <= w_red;
        r_vld  <= w_in_vld;
        r_mode <= w_in_mode;
      end
    end
  end

  assign out_valid = g_stage[LEVELS-1].r_vld;
  assign out_bit   = g_stage[LEVELS-1].r_node[0] ^ (g_stage[LEVELS-1].r_mode == MODE_NAND);

`ifdef KMER_REDUCE_HIT_CNT_EN
  logic [CNT_W-1:0] r_hit_count;

  // Saturating hit counter. A clear wins over a simultaneous hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_count <= '0;
    end else if (cnt_clear) begin
      r_hit_count <= '0;
    end else if (out_valid && out_bit && (r_hit_count != '1)) begin
      r_hit_count <= r_hit_count + CNT_W'(1);
    end
  end

  assign hit_count = r_hit_count;
`else
  logic w_unused_cnt_clear;

  assign w_unused_cnt_clear = cnt_clear;
  assign hit_count          = '0;
`endif

endmodule

// File: tb/tb_kmer_reduce_pipe.sv
// Scoreboard bench for kmer_reduce_pipe: default tree (11/4), WIDTH=1 and 64/2 instances
// share one stimulus stream. Counter expectations follow KMER_REDUCE_HIT_CNT_EN.
module tb_kmer_reduce_pipe;

  typedef struct {
    logic b;
    int   due;
  } exp_t;

  localparam int NDUT = 3;
`ifdef KMER_REDUCE_HIT_CNT_EN
  localparam int unsigned CNT_MAX = 15;
`else
  localparam int unsigned CNT_MAX = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        cnt_clear = 1'b0;
  logic [1:0]  in_mode = 2'b00;
  logic [63:0] stim = '0;

  logic        ov [NDUT];
  logic        ob [NDUT];
  logic [3:0]  hc0;
  logic [15:0] unused_hc1;
  logic [15:0] unused_hc2;

  exp_t        q [NDUT][$];
  int          edge_cnt = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  kmer_reduce_pipe #(.WIDTH(11), .FANIN(4), .CNT_W(4)) u_dut_w11 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(stim[10:0]),
    .in_mode(in_mode), .cnt_clear(cnt_clear),
    .out_valid(ov[0]), .out_bit(ob[0]), .hit_count(hc0)
  );

  kmer_reduce_pipe #(.WIDTH(1), .FANIN(4), .CNT_W(16)) u_dut_w1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(stim[0:0]),
    .in_mode(in_mode), .cnt_clear(cnt_clear),
    .out_valid(ov[1]), .out_bit(ob[1]), .hit_count(unused_hc1)
  );

  kmer_reduce_pipe #(.WIDTH(64), .FANIN(2), .CNT_W(16)) u_dut_w64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bits(stim),
    .in_mode(in_mode), .cnt_clear(cnt_clear),
    .out_valid(ov[2]), .out_bit(ob[2]), .hit_count(unused_hc2)
  );

  function automatic int lat_of(input int d);
    case (d)
      0:       return 2;
      1:       return 1;
      default: return 6;
    endcase
  endfunction

  function automatic int unsigned width_of(input int d);
    case (d)
      0:       return 11;
      1:       return 1;
      default: return 64;
    endcase
  endfunction

  function automatic logic ref_red(input logic [63:0] s, input logic [1:0] m, input int unsigned w);
    logic a;
    logic o;
    logic x;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int unsigned i = 0; i < w; i++) begin
      a = a & s[i];
      o = o | s[i];
      x = x ^ s[i];
    end
    case (m)
      2'b00:   return a;
      2'b01:   return o;
      2'b10:   return x;
      default: return ~a;
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Set inputs now; the beat is sampled at the next rising edge.
  task automatic drive(input logic v, input logic [1:0] m, input logic [63:0] s, input logic clr);
    exp_t e;
    in_valid  = v;
    in_mode   = m;
    stim      = s;
    cnt_clear = clr;
    if (v) begin
      for (int d = 0; d < NDUT; d++) begin
        e.b   = ref_red(s, m, width_of(d));
        e.due = edge_cnt + lat_of(d);
        q[d].push_back(e);
      end
    end
  endtask

  task automatic beat(input logic v, input logic [1:0] m, input logic [63:0] s, input logic clr);
    @(posedge clk);
    #1;
    drive(v, m, s, clr);
  endtask

  // Monitor: compare outputs against the scoreboard on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic expv;
    logic hit0;
    hit0 = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        check_eq($sformatf("d%0d_valid_in_reset", d), ov[d], 1'b0);
        q[d].delete();
      end else begin
        while (q[d].size() > 0 && q[d][0].due < edge_cnt) void'(q[d].pop_front());
        expv = (q[d].size() > 0) && (q[d][0].due == edge_cnt);
        check_eq($sformatf("d%0d_valid@%0d", d, edge_cnt), ov[d], expv);
        if (ov[d] && expv) begin
          e = q[d].pop_front();
          check_eq($sformatf("d%0d_bit@%0d", d, edge_cnt), ob[d], e.b);
          if (d == 0) hit0 = e.b;
        end
      end
    end
    check_eq("hit_count", hc0, reset ? 32'd0 : exp_cnt);
    if (reset || cnt_clear) exp_cnt = 0;
    else if (hit0 && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", ov[0], 1'b0);
    check_eq("rst_out_bit", ob[0], 1'b0);
    check_eq("rst_hit_count", hc0, 0);

    // First beat lands on the first edge with reset low.
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(1'b1, 2'b00, 64'h7FF, 1'b0);
    beat(1'b1, 2'b00, 64'h7FE, 1'b0);

    // Per-beat modes on 11'h001: AND, OR, XOR, NAND.
    for (int m = 0; m < 4; m++) beat(1'b1, 2'(m), 64'h001, 1'b0);

    // Short-group padding.
    beat(1'b1, 2'b01, 64'h400, 1'b0);
    beat(1'b1, 2'b10, 64'h600, 1'b0);
    repeat (8) beat(1'b0, 2'b00, 64'h0, 1'b0);

    // Valid gaps, then reset with beats in flight.
    beat(1'b1, 2'b00, 64'h7FF, 1'b0);
    beat(1'b0, 2'b00, 64'h7FF, 1'b0);
    beat(1'b1, 2'b01, 64'h003, 1'b0);
    beat(1'b1, 2'b10, 64'h001, 1'b0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (8) beat(1'b0, 2'b00, 64'h0, 1'b0);

    // Counter saturation.
    repeat (20) beat(1'b1, 2'b00, '1, 1'b0);
    repeat (8) beat(1'b0, 2'b00, 64'h0, 1'b0);
    @(negedge clk);
    check_eq("hit_sat", hc0, CNT_MAX);

    // Clear in the same cycle as a qualifying hit.
    for (int r = 0; r < 2; r++) begin
      beat(1'b1, 2'b00, '1, 1'b0);
      beat(1'b0, 2'b00, 64'h0, 1'b0);
      beat(1'b0, 2'b00, 64'h0, 1'b1);
      beat(1'b0, 2'b00, 64'h0, 1'b0);
      @(negedge clk);
      check_eq($sformatf("clr_priority_%0d", r), hc0, 0);
    end

    // Random sweep across all three trees.
    repeat (400) begin
      beat($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           {32'($urandom), 32'($urandom)}, $urandom_range(0, 15) == 0);
    end

    repeat (10) beat(1'b0, 2'b00, 64'h0, 1'b0);
    @(negedge clk);
    for (int d = 0; d < NDUT; d++) check_eq($sformatf("d%0d_drain", d), q[d].size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kmer_reduce_pipe.md
# kmer_reduce_pipe

- Pipelined, parametrised N-input bit-reduction unit for the seed-match path.
- Reduces a WIDTH-bit match vector to one bit per beat (AND, OR, XOR or NAND, selected per beat) through a registered FANIN-ary tree.
- Flags results with a valid strobe and optionally keeps a saturating hit count.
- Replaces fixed-width combinational AND gates feeding the word-hit logic behind the PCIe/Qsys datapath.

## Interface
- WIDTH, 11: number of input bits to reduce; legal range 1..256.
- FANIN, 4: inputs combined per tree node per stage; legal range 2..8.
- CNT_W, 16: width of hit_count.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all pipeline state and the counter.
- in_valid  in  1  beat qualifier for in_bits/in_mode.
- in_bits  in  WIDTH  vector to reduce.
- in_mode  in  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled with the beat.
- cnt_clear  in  1  synchronous clear of hit_count.
- out_valid  out  1  result qualifier; reset value 0.
- out_bit  out  1  reduction result; reset value 0.
- hit_count  out  CNT_W  saturating count of beats with out_valid=1 and out_bit=1; reset value 0.

## Operation
- LEVELS = number of tree stages = smallest L ≥ 1 with FANIN^L ≥ WIDTH.
  - WIDTH=11, FANIN=4 → 2.
  - WIDTH=1 → 1.
- Stage k holds ceil(WIDTH/FANIN^k) node registers, plus a valid bit and a 2-bit mode register.
- Stage 1 groups in_bits LSB-first into groups of FANIN. Each later stage groups the previous stage's nodes the same way.
- A short last group is padded with the identity value of the carried mode:
  - 1 for AND/NAND.
  - 0 for OR/XOR.
- Node operation per carried mode:
  - AND and NAND: AND of the group.
  - OR: OR of the group.
  - XOR: XOR of the group.
- NAND inversion is applied only at the final stage output, never in intermediate stages.
- Valid and mode travel with their data. Every beat is reduced with its own mode, so back-to-back beats may use different modes.
- Data registers load every cycle regardless of valid. out_bit is meaningful only while out_valid=1.
- No backpressure; a new beat is accepted every cycle.
- Counter (when compiled in):
  - Increments when out_valid=1 and out_bit=1.
  - Holds at 2^CNT_W−1.
  - cnt_clear=1 forces 0 on the next edge and takes priority over a simultaneous increment.

## Timing
- Latency: a beat presented at edge t appears on out_valid/out_bit after edge t+LEVELS−1, i.e. LEVELS register stages.
  - Default configuration: 2 cycles.
- Throughput: 1 beat/cycle. Gaps in in_valid reproduce as identical gaps in out_valid.
- hit_count updates one edge after the qualifying out_valid/out_bit cycle.
- Reset asserted mid-stream:
  - All valid bits, out_bit and hit_count go to 0 immediately (asynchronously).
  - In-flight beats are discarded and never emerge.
- First beat after reset deassertion: accepted at the first edge with reset low; its output follows LEVELS later.

## Configuration
- KMER_REDUCE_HIT_CNT_EN defined:
  - Counter logic present as described above.
- KMER_REDUCE_HIT_CNT_EN undefined:
  - No counter flops.
  - hit_count tied to 0.
  - cnt_clear ignored.
  - Pipeline behaviour unchanged.

## Test plan
- Defaults, AND mode: in_bits=11'h7FF valid for 1 cycle → out_valid=1, out_bit=1 exactly 2 cycles later. in_bits=11'h7FE → out_bit=0.
- Per-beat mode switch over four consecutive beats, in_bits=11'h001 with modes AND, OR, XOR, NAND → out_bit sequence 0,1,1,1 on four consecutive cycles.
- Padding check, WIDTH=11, FANIN=4:
  - OR mode, in_bits=11'h400 (only bit 10 set, in the short group) → out_bit=1.
  - XOR mode, in_bits=11'h600 → out_bit=0.
- Valid gaps and reset: in_valid pattern 1,0,1,1, then reset pulsed while 2 beats are in flight → out_valid pattern 1,0 before reset; 0 during and after reset; no stale beats emerge.
- Counter with macro defined, CNT_W=4:
  - 20 hitting beats → hit_count saturates at 15.
  - cnt_clear asserted in the same cycle as a hit → hit_count=0.
- Counter with macro undefined: the same stimulus leaves hit_count=0. Also sweep WIDTH=1 (latency 1) and WIDTH=64, FANIN=2 (latency 6) with random vectors against a reference model.
